// File: rtl/pattern_tx_if.sv
// ============================================================================
// pattern_tx_if : request/serial-output bundle for pattern_tx
// Revision      : 1.0
// ============================================================================
`default_nettype none

interface pattern_tx_if #(
  parameter int PW = 4
);
  logic          start;
  logic [PW-1:0] pattern;
  logic [3:0]    count;
  logic          stop;
  logic          x;
  logic          valid;
  logic          busy;
  logic          done;

  modport master (
    output start, pattern, count, stop,
    input  x, valid, busy, done
  );

  modport slave (
    input  start, pattern, count, stop,
    output x, valid, busy, done
  );
endinterface

`default_nettype wire

// File: rtl/pattern_tx.sv
// ============================================================================
// pattern_tx : serial burst transmitter, MSB first, count frames of PW bits.
// Option     : define PATTERN_TX_GAP_EN to insert one idle cycle between frames.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module pattern_tx #(
  parameter int            PW        = 4,
  parameter logic [PW-1:0] RESET_PAT = 4'b1001
) (
  input  wire logic   clk,
  input  wire logic   reset,
  pattern_tx_if.slave bus
);

  localparam int            BW       = (PW > 1) ? $clog2(PW) : 1;
  localparam logic [BW-1:0] LAST_BIT = BW'(PW - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    GAP   = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [PW-1:0] sr_q, sr_d;
  logic [PW-1:0] pat_q, pat_d;
  logic [3:0]    frames_q, frames_d;
  logic [BW-1:0] bit_q, bit_d;
  logic          stop_q, stop_d;

  logic          x_w, valid_w, busy_w, done_w;
  logic          stop_seen_w;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      sr_q     <= RESET_PAT;
      pat_q    <= RESET_PAT;
      frames_q <= 4'd0;
      bit_q    <= '0;
      stop_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sr_q     <= sr_d;
      pat_q    <= pat_d;
      frames_q <= frames_d;
      bit_q    <= bit_d;
      stop_q   <= stop_d;
    end
  end

  // A stop arriving on the last bit of a frame must still end the burst there.
  assign stop_seen_w = stop_q | bus.stop;

  always_comb begin
    state_d  = state_q;
    sr_d     = sr_q;
    pat_d    = pat_q;
    frames_d = frames_q;
    bit_d    = bit_q;
    stop_d   = stop_q;
    x_w      = 1'b0;
    valid_w  = 1'b0;
    busy_w   = 1'b0;
    done_w   = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start && (bus.count != 4'd0)) begin
          pat_d    = bus.pattern;
          sr_d     = bus.pattern;
          frames_d = bus.count;
          bit_d    = '0;
          state_d  = SHIFT;
        end
      end

      SHIFT: begin
        x_w     = sr_q[PW-1];
        valid_w = 1'b1;
        busy_w  = 1'b1;
        stop_d  = stop_seen_w;
        sr_d    = sr_q << 1;
        bit_d   = bit_q + BW'(1);
        if (bit_q == LAST_BIT) begin
          bit_d    = '0;
          sr_d     = pat_q;
          frames_d = frames_q - 4'd1;
          if ((frames_q != 4'd1) && !stop_seen_w) begin
`ifdef PATTERN_TX_GAP_EN
            state_d = GAP;
`else
            state_d = SHIFT;
`endif
          end else begin
            state_d = DONE;
          end
        end
      end

      GAP: begin
        busy_w  = 1'b1;
        stop_d  = stop_seen_w;
        state_d = SHIFT;
      end

      DONE: begin
        done_w  = 1'b1;
        stop_d  = 1'b0;
        state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.x     = x_w;
  assign bus.valid = valid_w;
  assign bus.busy  = busy_w;
  assign bus.done  = done_w;

endmodule

`default_nettype wire

// File: tb/tb_pattern_tx.sv
// ============================================================================
// tb_pattern_tx : directed bench with a queue-based burst model for pattern_tx
// Revision      : 1.0
// ============================================================================
`default_nettype none

module tb_pattern_tx;

  localparam int PW = 4;
`ifdef PATTERN_TX_GAP_EN
  localparam int GAP_CYC = 1;
`else
  localparam int GAP_CYC = 0;
`endif

  typedef struct {
    logic [3:0] o;      // {x, valid, busy, done}
    int         frame;
  } exp_t;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  pattern_tx_if #(.PW(PW)) bus ();

  pattern_tx #(.PW(PW), .RESET_PAT(4'b1001)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  exp_t       q[$];
  exp_t       cur;
  logic [3:0] act;
  int         tests = 0;
  int         fails = 0;
  int         cyc   = 0;
  int         base  = 0;
  logic [3:0] log_o [0:63];
  bit         armed = 1'b0;

  // Expected output stream of a whole burst, one entry per cycle after the start.
  function automatic void build(input logic [PW-1:0] pat, input logic [3:0] cnt);
    exp_t e;
    for (int f = 0; f < int'(cnt); f++) begin
      if (GAP_CYC != 0 && f > 0) begin
        e.o = 4'b0010; e.frame = f; q.push_back(e);
      end
      for (int b = 0; b < PW; b++) begin
        e.o = {pat[PW-1-b], 3'b110}; e.frame = f; q.push_back(e);
      end
    end
    e.o = 4'b0001; e.frame = -1; q.push_back(e);
  endfunction

  // Stop: keep only the frame in progress (or the one a gap leads into), then done.
  function automatic void truncate(input int f);
    exp_t keep[$];
    exp_t e;
    foreach (q[i]) if (!q[i].o[0] && q[i].frame <= f) keep.push_back(q[i]);
    q = keep;
    e.o = 4'b0001; e.frame = -1; q.push_back(e);
  endfunction

  always @(posedge clk) if (reset) armed <= 1'b1;

  always @(negedge clk) begin
    if (armed) begin
      if (q.size() > 0) cur = q.pop_front();
      else begin cur.o = 4'b0000; cur.frame = -1; end
      act = {bus.x, bus.valid, bus.busy, bus.done};
      tests++;
      if (act !== cur.o) begin
        fails++;
        $display("FAIL cycle_check cyc=%0d x/valid/busy/done got %b expected %b", cyc, act, cur.o);
      end
      if (cyc - base >= 0 && cyc - base < 64) log_o[cyc-base] = act;
      if (reset) q.delete();
      else begin
        if (bus.stop && cur.o[1]) truncate(cur.frame);
        if (bus.start && cur.o == 4'b0000 && q.size() == 0 && bus.count != 4'd0)
          build(bus.pattern, bus.count);
      end
    end
  end

  task automatic chk(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, actual, expected);
    end
  endtask

  task automatic step(input bit s, input bit sp, input bit r);
    bus.start = s;
    bus.stop  = sp;
    reset     = r;
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic newscen();
    base = cyc;
    for (int k = 0; k < 64; k++) log_o[k] = 4'b0000;
  endtask

  function automatic int cnt(input int bitn, input int lo, input int hi);
    int n = 0;
    for (int k = lo; k <= hi; k++) if (log_o[k][bitn]) n++;
    return n;
  endfunction

  function automatic int first_done();
    for (int k = 0; k < 64; k++) if (log_o[k][0]) return k;
    return -1;
  endfunction

  initial begin
    reset       = 1'b1;
    bus.start   = 1'b0;
    bus.stop    = 1'b0;
    bus.pattern = 4'b0000;
    bus.count   = 4'd0;
    step(0, 0, 1);
    newscen();
    step(0, 0, 1);
    step(0, 0, 0);
    chk("reset_outputs", int'(log_o[1]), 0);

    // Single frame of 1001
    bus.pattern = 4'b1001; bus.count = 4'd1;
    newscen();
    step(1, 0, 0);
    repeat (7) step(0, 0, 0);
    chk("s1_x_bits", int'({log_o[1][3], log_o[2][3], log_o[3][3], log_o[4][3]}), 9);
    chk("s1_valid_count", cnt(2, 0, 10), 4);
    chk("s1_done_cycle", first_done(), 5);
    chk("s1_busy_at_done", int'(log_o[5][1]), 0);

    // Three frames, contiguous or gapped
    bus.pattern = 4'b1001; bus.count = 4'd3;
    newscen();
    step(1, 0, 0);
    repeat (17) step(0, 0, 0);
    chk("s2_busy_cycles", cnt(1, 0, 20), 12 + 2 * GAP_CYC);
    chk("s2_valid_cycles", cnt(2, 0, 20), 12);
    chk("s2_done_cycle", first_done(), 13 + 2 * GAP_CYC);
    chk("s2_valid_c5", int'(log_o[5][2]), 1 - GAP_CYC);
    chk("s2_valid_c10", int'(log_o[10][2]), 1 - GAP_CYC);

    // count=5, stop during second frame
    bus.pattern = 4'b1011; bus.count = 4'd5;
    newscen();
    step(1, 0, 0);
    repeat (5) step(0, 0, 0);
    step(0, 1, 0);
    repeat (10) step(0, 0, 0);
    chk("s3_valid_count", cnt(2, 0, 20), 8);
    chk("s3_done_cycle", first_done(), 9 + GAP_CYC);

    // Start during burst ignored; stop on last bit of first frame
    bus.pattern = 4'b0110; bus.count = 4'd3;
    newscen();
    step(1, 0, 0);
    step(0, 0, 0);
    bus.pattern = 4'b1111; bus.count = 4'd9;
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 1, 0);
    repeat (5) step(0, 0, 0);
    chk("s4_x_bits", int'({log_o[1][3], log_o[2][3], log_o[3][3], log_o[4][3]}), 6);
    chk("s4_done_cycle", first_done(), 5);
    chk("s4_valid_count", cnt(2, 0, 10), 4);

    // Stop on cycle 5 (gap, or first bit of frame two)
    bus.pattern = 4'b1100; bus.count = 4'd3;
    newscen();
    step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    step(0, 1, 0);
    repeat (8) step(0, 0, 0);
    chk("s5_done_cycle", first_done(), 9 + GAP_CYC);

    // count=0 ignored
    bus.pattern = 4'b1111; bus.count = 4'd0;
    newscen();
    step(1, 0, 0);
    repeat (4) step(0, 0, 0);
    chk("s6_busy_count", cnt(1, 0, 5), 0);
    chk("s6_valid_count", cnt(2, 0, 5), 0);
    chk("s6_done_seen", first_done(), -1);

    // Reset on cycle 3 of a count=2 burst
    bus.pattern = 4'b1001; bus.count = 4'd2;
    newscen();
    step(1, 0, 0);
    step(0, 0, 0);
    step(0, 0, 0);
    step(0, 0, 1);
    repeat (10) step(0, 0, 0);
    chk("s7_after_reset", int'(log_o[4]), 0);
    chk("s7_valid_count", cnt(2, 0, 14), 3);
    chk("s7_no_done", first_done(), -1);

    // Recovery burst after abort
    bus.pattern = 4'b0101; bus.count = 4'd2;
    newscen();
    step(1, 0, 0);
    repeat (12) step(0, 0, 0);
    chk("s8_done_cycle", first_done(), 9 + GAP_CYC);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

`default_nettype wire
